// File: rtl/sk_eta_pack.sv
// Packs the eta=2 secret vectors s1||s2 from NTT RAM into the 3-bit-per-coefficient
// skEncode stream, written as 64-bit words into raw data RAM.
module sk_eta_pack #(
  parameter int unsigned K                    = 8,
  parameter int unsigned L                    = 7,
  parameter int unsigned N                    = 256,
  parameter int unsigned ETA                  = 2,
  parameter int unsigned Q                    = 8380417,
  parameter int unsigned COEFF_WIDTH          = 24,
  parameter int unsigned COEFF_PER_WORD       = 4,
  parameter int unsigned WORD_COEFF           = COEFF_WIDTH * COEFF_PER_WORD,
  parameter int unsigned NTT_ADDR_WIDTH       = 12,
  parameter int unsigned VECTOR_S_BASE_OFFSET = 0,
  parameter int unsigned WORD_WIDTH           = 64,
  parameter int unsigned DATA_ADDR_WIDTH      = 12,
  parameter int unsigned SK_S_BASE_OFFSET     = 0,
  parameter int unsigned PACK_BITS            = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       done,
  output logic                       err,
  output logic                       re_vector_s,
  output logic [NTT_ADDR_WIDTH-1:0]  addr_vector_s,
  input  logic [WORD_COEFF-1:0]      dout_vector_s,
  output logic                       we_sk,
  output logic [DATA_ADDR_WIDTH-1:0] addr_sk,
  output logic [WORD_WIDTH-1:0]      din_sk
);

  localparam int unsigned NW_IN    = (K + L) * N / COEFF_PER_WORD;
  localparam int unsigned NW_OUT   = (K + L) * N * PACK_BITS / WORD_WIDTH;
  localparam int unsigned IN_BITS  = COEFF_PER_WORD * PACK_BITS;
  localparam int unsigned BUF_W    = WORD_WIDTH + IN_BITS;
  localparam int unsigned CNT_W    = $clog2(BUF_W + 1);
  localparam int unsigned IN_IDX_W = $clog2(NW_IN + 1);
  localparam int unsigned OUT_W    = $clog2(NW_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_APPEND, S_EMIT, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [IN_IDX_W-1:0]        in_idx_q, in_idx_d;
  logic [OUT_W-1:0]           out_idx_q, out_idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BUF_W-1:0]           buf_q, buf_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       re_q, re_d;
  logic [NTT_ADDR_WIDTH-1:0]  raddr_q, raddr_d;
  logic                       we_q, we_d;
  logic [DATA_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_WIDTH-1:0]      wdata_q, wdata_d;

  logic [IN_BITS-1:0]         lanes_v;
  logic                       lanes_bad;

  // Map one stored coefficient c to ETA - c mod Q; flag anything outside [-ETA, ETA].
  function automatic logic [PACK_BITS:0] eta_map(input logic [COEFF_WIDTH-1:0] c);
    int unsigned cu;
    logic [PACK_BITS:0] r;
    cu = 32'(c);
    r  = '0;
    if (cu <= ETA) begin
      r[PACK_BITS-1:0] = PACK_BITS'(ETA - cu);
    end else if ((cu >= Q - ETA) && (cu < Q)) begin
      r[PACK_BITS-1:0] = PACK_BITS'(ETA + Q - cu);
    end else begin
      r[PACK_BITS] = 1'b1;
    end
    return r;
  endfunction

  // Pack all lanes of the current NTT word into one IN_BITS chunk.
  always_comb begin
    logic [PACK_BITS:0] m;
    lanes_v   = '0;
    lanes_bad = 1'b0;
    for (int j = 0; j < int'(COEFF_PER_WORD); j++) begin
      m = eta_map(dout_vector_s[COEFF_WIDTH*j +: COEFF_WIDTH]);
      lanes_v[PACK_BITS*j +: PACK_BITS] = m[PACK_BITS-1:0];
      lanes_bad = lanes_bad | m[PACK_BITS];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT:   state_d = S_APPEND;
      S_APPEND: state_d = ((cnt_q + CNT_W'(IN_BITS)) >= CNT_W'(WORD_WIDTH)) ? S_EMIT : S_REQ;
      S_EMIT:   state_d = (out_idx_q == OUT_W'(NW_OUT - 1)) ? S_DONE : S_REQ;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values, keyed to the upcoming state.
  always_comb begin
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    err_d     = err_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_idx_d  = '0;
          out_idx_d = '0;
          cnt_d     = '0;
          buf_d     = '0;
          err_d     = 1'b0;
        end
      end
      S_APPEND: begin
        buf_d    = buf_q | (BUF_W'(lanes_v) << cnt_q);
        cnt_d    = cnt_q + CNT_W'(IN_BITS);
        in_idx_d = in_idx_q + IN_IDX_W'(1);
        if (lanes_bad) err_d = 1'b1;
      end
      S_EMIT: begin
        buf_d     = buf_q >> WORD_WIDTH;
        cnt_d     = cnt_q - CNT_W'(WORD_WIDTH);
        out_idx_d = out_idx_q + OUT_W'(1);
      end
      default: ;
    endcase
    re_d   = (state_d == S_REQ);
    we_d   = (state_d == S_EMIT);
    done_d = (state_d == S_DONE);
    if (state_d == S_REQ)
      raddr_d = NTT_ADDR_WIDTH'(VECTOR_S_BASE_OFFSET) + NTT_ADDR_WIDTH'(in_idx_d);
    if (state_d == S_EMIT) begin
      wdata_d = buf_d[WORD_WIDTH-1:0];
      waddr_d = DATA_ADDR_WIDTH'(SK_S_BASE_OFFSET) + DATA_ADDR_WIDTH'(out_idx_q);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx_q  <= '0;
      out_idx_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      re_q      <= 1'b0;
      raddr_q   <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      done_q    <= done_d;
      err_q     <= err_d;
      re_q      <= re_d;
      raddr_q   <= raddr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign done          = done_q;
  assign err           = err_q;
  assign re_vector_s   = re_q;
  assign addr_vector_s = raddr_q;
  assign we_sk         = we_q;
  assign addr_sk       = waddr_q;
  assign din_sk        = wdata_q;

endmodule
